fifo_drain_ctrl: RTL and testbench

Read-side consumer for the async FIFO, clocked in the FIFO read domain. Pops one word whenever the FIFO is non-empty and the downstream serial transmitter is idle, and presents it as a one-cycle valid pulse. It then tracks the transmitter's busy handshake to frame completion before popping the next word. It sits between the FIFO read port (empty/rd_data/r_inc) and the UART-style transmitter (data/valid/busy).

---
 rtl/fifo_drain_ctrl.sv | 138 +++++++++++++
 tb/tb_fifo_drain_ctrl.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_ctrl.sv
// rtl/fifo_drain_ctrl.sv - FIFO read-side drain controller feeding a serial transmitter (optional macro FIFO_DRAIN_TIMEOUT_EN)
module fifo_drain_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int CNT_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TMR_WIDTH      = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  drain_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_r_inc,
  input  logic                  tx_busy,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic                  timeout_err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    RESEND    = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  // The ack timer must be able to count up to TIMEOUT_CYCLES-1
  if (TIMEOUT_CYCLES < 2 || (TIMEOUT_CYCLES - 1) >= (1 << TMR_WIDTH)) begin : g_bad_timeout_cfg
    $error("fifo_drain_ctrl: TMR_WIDTH cannot hold TIMEOUT_CYCLES-1");
  end

`ifdef FIFO_DRAIN_TIMEOUT_EN
  localparam logic [TMR_WIDTH-1:0] TMR_LAST = TMR_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TMR_WIDTH-1:0] timer;
  logic                 ack_expired;

  assign ack_expired = (state == WAIT_ACK) && !tx_busy && (timer == TMR_LAST);

  // Ack-wait timer: zero outside WAIT_ACK so every (re)send starts a fresh window
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      timer <= '0;
    end else if (state != WAIT_ACK) begin
      timer <= '0;
    end else if (!tx_busy) begin
      timer <= timer + 1'b1;
    end
  end

  // Sticky timeout flag, raised on the cycle the ack window expires
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      timeout_err <= 1'b0;
    end else if (ack_expired) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: one word per frame, frame ends when busy falls
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (drain_en && !fifo_empty && !tx_busy) begin
          state_nxt = SEND;
        end
      end
      SEND: begin
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
`ifdef FIFO_DRAIN_TIMEOUT_EN
        end else if (ack_expired) begin
          state_nxt = RESEND;
`endif
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_nxt = IDLE;
        end
      end
`ifdef FIFO_DRAIN_TIMEOUT_EN
      RESEND: begin
        state_nxt = WAIT_ACK;
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Moore outputs: start pulse on every (re)send, pop only on the first send
  always_comb begin
    tx_valid   = (state == SEND) || (state == RESEND);
    fifo_r_inc = (state == SEND);
  end

  // Capture the FIFO head on the accept edge; it is held for retries
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_data <= '0;
    end else if ((state == IDLE) && (state_nxt == SEND)) begin
      tx_data <= fifo_rd_data;
    end
  end

  // Completed-frame counter, bumped when the transmitter drops busy
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      frame_cnt <= '0;
    end else if ((state == WAIT_DONE) && !tx_busy) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// tb/tb_fifo_drain_ctrl.sv - randomized self-checking bench for fifo_drain_ctrl
module tb_fifo_drain_ctrl;

  localparam int DW = 8;
  localparam int CW = 4;
  localparam int TO = 8;
  localparam int TW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          drain_en = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_r_inc;
  logic          tx_busy = 1'b0;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic [CW-1:0] frame_cnt;
  logic          timeout_err;

  fifo_drain_ctrl #(
    .DATA_WIDTH(DW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO), .TMR_WIDTH(TW)
  ) dut (
    .CLK(CLK), .RST(RST), .drain_en(drain_en), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_r_inc(fifo_r_inc), .tx_busy(tx_busy),
    .tx_data(tx_data), .tx_valid(tx_valid), .frame_cnt(frame_cnt),
    .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Environment model: FIFO contents, transmitter behaviour, event logs
  logic [DW-1:0] q[$];
  logic [DW-1:0] valid_dat[$];
  int            valid_cyc[$];
  int            inc_cyc[$];
  int            busy_len_log[$];
  int            cyc;
  int            busy_left;
  int            busy_min;
  int            busy_max;
  int            exp_frames;
  int            pops;
  int            bad_pops;
  bit            pop_pending;
  bit            rise_pending;
  bit            fall_pending;
  bit            tx_resp;

  task automatic drive_fifo();
    fifo_empty   = (q.size() == 0);
    fifo_rd_data = (q.size() != 0) ? q[0] : DW'($urandom);
  endtask

  task automatic reset_model();
    q.delete(); valid_dat.delete(); valid_cyc.delete(); inc_cyc.delete(); busy_len_log.delete();
    cyc = 0; busy_left = 0; exp_frames = 0; pops = 0; bad_pops = 0;
    pop_pending = 0; rise_pending = 0; fall_pending = 0;
    tx_resp = 1; busy_min = 1; busy_max = 4;
    tx_busy = 1'b0;
    drive_fifo();
  endtask

  // One clock: advance FIFO and transmitter models, log what the DUT did this cycle
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    if (pop_pending) begin
      void'(q.pop_front());
      pop_pending = 0;
    end
    if (fall_pending) begin
      exp_frames++;
      fall_pending = 0;
    end
    if (tx_busy && busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        tx_busy = 1'b0;
        fall_pending = 1;
      end
    end
    if (rise_pending) begin
      rise_pending = 0;
      busy_left = int'($urandom_range(busy_max, busy_min));
      busy_len_log.push_back(busy_left);
      tx_busy = 1'b1;
    end
    if (tx_valid === 1'b1) begin
      valid_cyc.push_back(cyc);
      valid_dat.push_back(tx_data);
      if (tx_resp) rise_pending = 1;
    end
    if (fifo_r_inc === 1'b1) begin
      pops++;
      inc_cyc.push_back(cyc);
      if (q.size() == 0) bad_pops++;
      else pop_pending = 1;
    end
    drive_fifo();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    RST = 1'b0;
    drain_en = 1'b0;
    reset_model();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
  endtask

  task automatic test_reset();
    reset_model();
    q.push_back(8'h3C);
    busy_min = 2; busy_max = 2;
    drain_en = 1'b1;
    drive_fifo();
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      checks++;
      if ({tx_valid, fifo_r_inc, tx_data, frame_cnt, timeout_err} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d got %0h want 0", i,
                 {tx_valid, fifo_r_inc, tx_data, frame_cnt, timeout_err});
      end
    end
    RST = 1'b1;
    tick();
    checks++;
    if (tx_valid !== 1'b1 || fifo_r_inc !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_valid got valid=%b inc=%b want 1 1", tx_valid, fifo_r_inc);
    end
    checks++;
    if (tx_data !== 8'h3C) begin
      errors++;
      $display("FAIL reset_first_data got %0h want 3c", tx_data);
    end
    run(10);
    checks++;
    if (frame_cnt !== CW'(1) || pops != 1) begin
      errors++;
      $display("FAIL reset_first_frame got cnt=%0d pops=%0d want 1 1", frame_cnt, pops);
    end
  endtask

  task automatic test_single();
    int bad_track;
    do_reset();
    busy_min = 10; busy_max = 10;
    q.push_back(8'hA5);
    drain_en = 1'b1;
    drive_fifo();
    bad_track = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (frame_cnt !== CW'(exp_frames)) bad_track++;
    end
    checks++;
    if (bad_track != 0) begin
      errors++;
      $display("FAIL single_frame_cnt_timing got %0d bad cycles want 0", bad_track);
    end
    checks++;
    if (valid_dat.size() != 1 || pops != 1) begin
      errors++;
      $display("FAIL single_counts got valids=%0d pops=%0d want 1 1", valid_dat.size(), pops);
    end else begin
      checks++;
      if (valid_dat[0] !== 8'hA5 || valid_cyc[0] != inc_cyc[0]) begin
        errors++;
        $display("FAIL single_pulse got data=%0h vcyc=%0d icyc=%0d want a5 same", valid_dat[0], valid_cyc[0], inc_cyc[0]);
      end
    end
    checks++;
    if (frame_cnt !== CW'(1) || tx_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_end got cnt=%0d data=%0h want 1 a5", frame_cnt, tx_data);
    end
  endtask

  task automatic test_burst();
    int start;
    do_reset();
    busy_min = 1; busy_max = 6;
    q = '{8'h11, 8'h22, 8'h33};
    drain_en = 1'b1;
    drive_fifo();
    start = cyc;
    run(50);
    checks++;
    if (valid_dat.size() != 3 || pops != 3 || bad_pops != 0) begin
      errors++;
      $display("FAIL burst_counts got valids=%0d pops=%0d bad=%0d want 3 3 0", valid_dat.size(), pops, bad_pops);
    end else begin
      checks++;
      if (valid_dat[0] !== 8'h11 || valid_dat[1] !== 8'h22 || valid_dat[2] !== 8'h33) begin
        errors++;
        $display("FAIL burst_order got %0h %0h %0h want 11 22 33", valid_dat[0], valid_dat[1], valid_dat[2]);
      end
      checks++;
      if (valid_cyc[0] != start + 1) begin
        errors++;
        $display("FAIL burst_latency got %0d want %0d", valid_cyc[0], start + 1);
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (valid_cyc[i+1] - valid_cyc[i] != busy_len_log[i] + 3) begin
          errors++;
          $display("FAIL burst_spacing%0d got %0d want %0d", i, valid_cyc[i+1] - valid_cyc[i], busy_len_log[i] + 3);
        end
      end
    end
    checks++;
    if (frame_cnt !== CW'(3)) begin
      errors++;
      $display("FAIL burst_frames got %0d want 3", frame_cnt);
    end
  endtask

  task automatic test_gating();
    int seen;
    int s;
    do_reset();
    busy_min = 5; busy_max = 5;
    q = '{8'h5A, 8'h6B};
    drive_fifo();
    run(20);
    checks++;
    if (valid_dat.size() != 0 || pops != 0) begin
      errors++;
      $display("FAIL gate_disabled got valids=%0d pops=%0d want 0 0", valid_dat.size(), pops);
    end
    drain_en = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (tx_busy) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL gate_busy_timeout got no busy want busy within 10");
    end
    tick();
    drain_en = 1'b0;
    run(30);
    checks++;
    if (valid_dat.size() != 1 || frame_cnt !== CW'(1) || q.size() != 1) begin
      errors++;
      $display("FAIL gate_drop got valids=%0d cnt=%0d left=%0d want 1 1 1", valid_dat.size(), frame_cnt, q.size());
    end
    // transmitter busy in IDLE holds off the start
    do_reset();
    q.push_back(8'h77);
    drain_en = 1'b1;
    tx_busy = 1'b1;
    drive_fifo();
    run(10);
    checks++;
    if (valid_dat.size() != 0) begin
      errors++;
      $display("FAIL gate_busy_idle got valids=%0d want 0", valid_dat.size());
    end
    tx_busy = 1'b0;
    s = cyc;
    run(3);
    checks++;
    if (valid_cyc.size() != 1 || valid_cyc[0] != s + 1) begin
      errors++;
      $display("FAIL gate_busy_release got n=%0d want valid at %0d", valid_cyc.size(), s + 1);
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] sent[$];
    int bad_track;
    do_reset();
    busy_min = 1; busy_max = 3;
    for (int i = 0; i < 16; i++) begin
      sent.push_back(DW'($urandom));
      q.push_back(sent[i]);
    end
    drain_en = 1'b1;
    drive_fifo();
    bad_track = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (frame_cnt !== CW'(exp_frames)) bad_track++;
    end
    checks++;
    if (bad_track != 0 || exp_frames != 16) begin
      errors++;
      $display("FAIL wrap_track got bad=%0d frames=%0d want 0 16", bad_track, exp_frames);
    end
    checks++;
    if (frame_cnt !== '0) begin
      errors++;
      $display("FAIL wrap_cnt got %0d want 0", frame_cnt);
    end
    checks++;
    if (valid_dat.size() != 16 || pops != 16) begin
      errors++;
      $display("FAIL wrap_counts got valids=%0d pops=%0d want 16 16", valid_dat.size(), pops);
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (valid_dat[i] !== sent[i]) begin
          errors++;
          $display("FAIL wrap_data%0d got %0h want %0h", i, valid_dat[i], sent[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] sent[$];
    int n_bad;
    do_reset();
    busy_min = 1; busy_max = 5;
    drain_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        sent.push_back(DW'($urandom));
        q.push_back(sent[sent.size()-1]);
        drive_fifo();
      end
      if ($urandom_range(0, 19) == 0) drain_en = ~drain_en;
      tick();
    end
    drain_en = 1'b1;
    for (int i = 0; i < 1500 && (q.size() != 0 || valid_dat.size() < sent.size()); i++) tick();
    run(15);
    checks++;
    if (valid_dat.size() != sent.size() || pops != sent.size() || bad_pops != 0) begin
      errors++;
      $display("FAIL random_counts got valids=%0d pops=%0d bad=%0d want %0d %0d 0",
               valid_dat.size(), pops, bad_pops, sent.size(), sent.size());
    end else begin
      n_bad = 0;
      for (int i = 0; i < sent.size(); i++) if (valid_dat[i] !== sent[i]) n_bad++;
      checks++;
      if (n_bad != 0) begin
        errors++;
        $display("FAIL random_order got %0d wrong words want 0", n_bad);
      end
    end
    checks++;
    if (frame_cnt !== CW'(sent.size())) begin
      errors++;
      $display("FAIL random_frames got %0d want %0d", frame_cnt, CW'(sent.size()));
    end
  endtask

  task automatic test_timeout();
    int seen;
    do_reset();
    tx_resp = 0;
    q = '{8'hC3, 8'h44};
    drain_en = 1'b1;
    drive_fifo();
    seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      tick();
      if (valid_dat.size() != 0) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL timeout_first_valid got none want within 5");
    end
`ifdef FIFO_DRAIN_TIMEOUT_EN
    run(27);
    checks++;
    if (valid_dat.size() != 4 || pops != 1 || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_resend got valids=%0d pops=%0d err=%b want 4 1 1", valid_dat.size(), pops, timeout_err);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (valid_cyc[i+1] - valid_cyc[i] != TO + 1 || valid_dat[i+1] !== 8'hC3) begin
          errors++;
          $display("FAIL timeout_repeat%0d got gap=%0d data=%0h want %0d c3", i, valid_cyc[i+1] - valid_cyc[i], valid_dat[i+1], TO + 1);
        end
      end
    end
`else
    run(40);
    checks++;
    if (valid_dat.size() != 1 || pops != 1 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_disabled got valids=%0d pops=%0d err=%b want 1 1 0", valid_dat.size(), pops, timeout_err);
    end
`endif
  endtask

  initial begin
    #2;
    RST = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_gating();
    test_wrap();
    test_random();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
